// File: rtl/mandelbrot_pixel_sink.sv
// Mandelbrot pixel sink: issues one engine run per pixel, packs two 4-bit
// counts per byte and streams them out through a small FIFO.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   enable         start frames continuously while high (sampled in IDLE)
//   eng_run        one-cycle start request to the engine
//   eng_running    engine busy flag
//   eng_finished   engine end-of-frame flag (cross-checked only)
//   eng_ctr        engine iteration count, valid while eng_running=0
//   out_valid      FIFO head valid
//   out_ready      consumer accepts the head
//   out_data       [3:0] even (left) pixel, [7:4] odd (right) pixel
//   out_sof        head byte is the first byte of a frame
//   out_eol        head byte is the last byte of a line
//   frame_done     one-cycle pulse after the last capture of a frame
//   frame_err      sticky engine/sink frame-position disagreement
module mandelbrot_pixel_sink #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       eng_run,
  input  logic       eng_running,
  input  logic       eng_finished,
  input  logic [3:0] eng_ctr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eol,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [XW-1:0] x_q;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_q;
  logic [YW-1:0] y_d;
  logic [3:0]    hold_q;
  logic [3:0]    hold_d;
  logic          frame_err_q;
  logic          frame_err_d;

  logic [9:0]    mem_q [DEPTH];
  logic [9:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic          fifo_full;
  logic          capture;
  logic          last_x;
  logic          last_y;
  logic          last_pix;
  logic          push;
  logic          pop;
  logic          entry_sof;
  logic          entry_eol;
  logic [9:0]    entry;
  logic [9:0]    head;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Holding here is safe: the engine keeps its coordinates while idle.
        if (!fifo_full) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!eng_running) begin
          state_d = last_pix ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    eng_run    = 1'b0;
    frame_done = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      S_IDLE:  ;
      S_ISSUE: eng_run    = !fifo_full;
      S_BUSY:  capture    = !eng_running;
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- pixel position and packing ----------------
  assign last_x   = (x_q == X_LAST);
  assign last_y   = (y_q == Y_LAST);
  assign last_pix = last_x && last_y;

  // Odd pixels complete a byte; even pixels wait in the hold register.
  assign push      = capture && x_q[0];
  assign entry_sof = (y_q == '0) && (x_q == XW'(1));
  assign entry_eol = last_x;
  assign entry     = {entry_eol, entry_sof, eng_ctr, hold_q};

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    hold_d      = hold_q;
    frame_err_d = frame_err_q;
    if (capture) begin
      if (!x_q[0]) begin
        hold_d = eng_ctr;
      end
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      // Engine must flag end-of-frame exactly on our last pixel.
      if (last_pix ? !eng_finished : eng_finished) begin
        frame_err_d = 1'b1;
      end
    end
    if (state_q == S_DONE) begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      hold_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      hold_q      <= hold_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------- output FIFO ----------------
  assign fifo_full = (count_q == C_FULL);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Only one pixel is ever in flight, so the full guard never blocks
    // a real push; it just keeps the FIFO self-consistent.
    if (push && !fifo_full) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q
            + CW'(push && !fifo_full)
            - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_data  = head[7:0];
  assign out_sof   = head[8];
  assign out_eol   = head[9];
  assign frame_err = frame_err_q;

endmodule

// File: doc/mandelbrot_pixel_sink.md
# mandelbrot_pixel_sink

Frame controller and pixel collector on the initiator side of the Mandelbrot engine's run/running handshake. It issues one `run` per pixel and captures the 4-bit iteration count when the engine goes idle. It packs two pixels per byte and buffers the bytes in a small FIFO. It presents the bytes on a valid/ready stream with start-of-frame and end-of-line markers, for the output serializer or host port.

## Interface
- `WIDTH`, 320: pixels per line; must be even and must match the engine's `WIDTH`.
- `HEIGHT`, 240: lines per frame; must match the engine's `HEIGHT`.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high. The engine shares this reset.
- `enable` in 1: start frames continuously while high; sampled only in IDLE.
- `eng_run` out 1: single-cycle start request to the engine.
- `eng_running` in 1: engine busy flag.
- `eng_finished` in 1: engine end-of-frame flag; monitored only.
- `eng_ctr` in 4: engine iteration count; valid while `eng_running`=0.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out 8: `[3:0]` = even (left) pixel, `[7:4]` = odd (right) pixel.
- `out_sof` out 1: head byte is the first byte of a frame.
- `out_eol` out 1: head byte is the last byte of a line.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is captured.
- `frame_err` out 1: sticky flag; `eng_finished` state disagreed with the sink's own count.

## Operation
- **State machine:** states are IDLE, ISSUE, BUSY, DONE.
- **IDLE:** if `enable`=1, go to ISSUE.
- **ISSUE:**
  - If FIFO count < DEPTH: `eng_run`=1 combinationally for this cycle, then go to BUSY.
  - Otherwise hold in ISSUE with `eng_run`=0.
  - Pixels are never dropped. The engine holds its coordinates while idle, so stalling is safe.
- **BUSY:**
  - `eng_running` is 1 on the first BUSY cycle.
  - On the first BUSY cycle with `eng_running`=0, capture `eng_ctr` and advance `x` and `y`.
  - If that pixel was `x`=WIDTH-1 and `y`=HEIGHT-1, go to DONE; otherwise go to ISSUE.
- **DONE:** pulse `frame_done`, clear `x` and `y`, go to IDLE.
- **Pixel counters:**
  - `x` has $clog2(WIDTH) bits; `y` has $clog2(HEIGHT) bits.
  - `x` wraps to 0 at WIDTH-1 and `y` increments at that point.
  - Both counters are independent of the engine's own counters.
- **Packing:**
  - Even-`x` pixel: store into a nibble holding register; no push.
  - Odd-`x` pixel: push {eol, sof, ctr, hold} into the FIFO.
  - sof = (`y`=0 and `x`=1); eol = (`x`=WIDTH-1).
  - FIFO entry width is 10 bits.
- **FIFO:**
  - Circular buffer with read/write pointers and a count of $clog2(DEPTH)+1 bits.
  - `out_valid` = count≠0; `out_data`, `out_sof` and `out_eol` come from the head entry.
  - A pop occurs when `out_valid` and `out_ready` are both 1.
  - Simultaneous push and pop leaves count unchanged.
  - No push when full; this is guaranteed by the ISSUE gating because only one pixel is ever in flight.
  - Pop when empty is ignored.
- **Frame check:** at each capture, set `frame_err` if either condition holds:
  - last pixel of the frame is captured and `eng_finished`=0, or
  - any other pixel is captured and `eng_finished`=1.
- **Reset:**
  - State goes to IDLE; `x`, `y`, FIFO pointers, count and hold register go to 0.
  - All outputs go to 0: `eng_run`, `out_valid`, `out_data`, `out_sof`, `out_eol`, `frame_done`, `frame_err`.
  - Reset mid-frame discards the partial frame and all FIFO contents.
  - The engine resets together with the sink, so the engine has `finished`=1 and the next `run` restarts at the first coordinate.
- **Dropping `enable`:** mid-frame has no effect; the frame completes. The sink then stays in IDLE after DONE.

## Timing
- `eng_run` is asserted in ISSUE and sampled at edge E. BUSY starts at E.
- The engine finishes at edge F ≥ E+1. The sink sees `eng_running`=0 in cycle F and captures at edge F+1.
- For an odd pixel, the byte becomes visible on `out_valid` in the cycle after F+1.
- The next `eng_run` is asserted in the cycle after F+1. Per-pixel overhead is 2 cycles beyond engine busy time.
- `frame_done` is high for exactly the one cycle after the final capture edge. The earliest next `eng_run` is 2 cycles after that.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Test plan
Bench setup: WIDTH=4, HEIGHT=2, DEPTH=2, with a behavioral engine model using programmable busy cycles and count values.

- **Full frame:** counts 1..8, busy 1 cycle each, `out_ready`=1.
  - Expect bytes 0x21 (sof), 0x43 (eol), 0x65 (sof=0), 0x87 (eol).
  - Expect `frame_done` pulsed once and `frame_err`=0.
- **Backpressure:** `out_ready`=0 for the whole frame.
  - After 2 bytes are pushed, `eng_run` stays 0 and `out_data` stays 0x21.
  - When `out_ready` rises, all 4 bytes drain in order and no pixel is lost.
- **Simultaneous push and pop:** `out_ready`=1 with 1 entry queued, on the cycle of the odd capture.
  - Count stays 1 and `out_data` changes to the new byte on the next cycle.
- **Variable busy time:** busy times 1, 7 and 30 cycles.
  - `eng_run` fires exactly 2 cycles after each falling `eng_running`.
  - Exactly 8 runs are issued per frame.
- **Reset mid-frame:** assert `reset` after pixel 3.
  - All outputs go to 0 and the FIFO is empty.
  - The next frame with `enable`=1 starts with a sof byte.
- **Engine mismatch:** the model drives `eng_finished`=1 at pixel 5.
  - `frame_err` goes to 1 at that capture and stays 1 until reset.
